// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller and the ALU control block.
// Contents: opcode constants, 4-bit state encodings, alu_op / alu_src_b /
// pc_source encodings and the packed control vector driven to the datapath.
`timescale 1ns/1ps
package mips_multicycle_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // ALU operation requested from ALU control
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRC_B_RT      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_SEXT    = 2'b10;
  localparam logic [1:0] SRC_B_SEXT_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_out_decode.sv
// Combinational output decoder for the multicycle controller.
// Ports: state (current FSM state), mem_ready, zero -> ctrl (datapath control
// vector) and retire (high in the cycle an instruction completes).
`timescale 1ns/1ps
module mips_multicycle_ctrl_out_decode
  import mips_multicycle_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl,
  output logic   retire
);

  always_comb begin
    ctrl   = '0;
    retire = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        // IR load and PC+4 only commit on the cycle the fetch completes
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Precompute branch target into ALUOut
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRC_B_SEXT_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_SEXT;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
        retire          = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        retire         = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_RT;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        retire         = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_RT;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PC_SRC_ALUOUT;
        ctrl.pc_write  = zero;
        retire         = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_source = PC_SRC_JUMP;
        ctrl.pc_write  = 1'b1;
        retire         = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        retire         = 1'b1;
      end
      default: begin
        // S_TRAP and unused encodings: everything stays 0
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencing controller.
// Ports: clk, reset (async, active-high), opcode (IR[31:26]), zero (ALU flag),
// mem_ready (memory handshake) -> datapath enables/selects, halted (sticky
// illegal-opcode trap) and retired (count of completed instructions, CNT_W bits).
`timescale 1ns/1ps
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] retired_reg;
  ctrl_t            dec_ctrl, ctrl;
  logic             retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) retired_reg <= retired_reg + CNT_ONE;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_R:         state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDI_EX;
          default:      state_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_next = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
      S_EXEC:     state_next = S_R_WB;
      S_ADDI_EX:  state_next = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_TRAP;
    endcase
  end

  mips_multicycle_ctrl_out_decode u_out_decode (
    .state     (state_reg),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (dec_ctrl),
    .retire    (retire)
  );

  // Force outputs low combinationally so a pending write is dropped in the
  // same cycle reset rises, without waiting for the state register to clear.
  assign ctrl = reset ? '0 : dec_ctrl;

  assign pc_write   = ctrl.pc_write;
  assign ir_write   = ctrl.ir_write;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_dst    = ctrl.reg_dst;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;

  assign halted  = (state_reg == S_TRAP) && !reset;
  assign retired = retired_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for mips_multicycle_ctrl (CNT_W=4 so the counter wrap is reachable).
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write, ir_write, i_or_d, mem_read, mem_write;
  logic             mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic             halted;
  logic [CNT_W-1:0] retired;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CNT_W-1:0] exp_ret;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .halted     (halted),
    .retired    (retired)
  );

  // Observed vector: pc_write ir_write i_or_d mem_read mem_write mem_to_reg
  //                  reg_dst reg_write alu_src_a alu_src_b alu_op pc_source
  logic [14:0] ctrl_obs;
  assign ctrl_obs = {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
                     reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  // Hand-written expected vectors, one per state
  localparam logic [14:0] E_ZERO     = 15'b0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [14:0] E_FETCH_R  = 15'b1_1_0_1_0_0_0_0_0_01_00_00;
  localparam logic [14:0] E_FETCH_W  = 15'b0_0_0_1_0_0_0_0_0_01_00_00;
  localparam logic [14:0] E_DECODE   = 15'b0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [14:0] E_MEM_ADDR = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [14:0] E_MEM_RD   = 15'b0_0_1_1_0_0_0_0_0_00_00_00;
  localparam logic [14:0] E_MEM_WB   = 15'b0_0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [14:0] E_MEM_WR   = 15'b0_0_1_0_1_0_0_0_0_00_00_00;
  localparam logic [14:0] E_EXEC     = 15'b0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [14:0] E_R_WB     = 15'b0_0_0_0_0_0_1_1_0_00_00_00;
  localparam logic [14:0] E_BR_Z1    = 15'b1_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [14:0] E_BR_Z0    = 15'b0_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [14:0] E_JUMP     = 15'b1_0_0_0_0_0_0_0_0_00_00_10;
  localparam logic [14:0] E_ADDI_WB  = 15'b0_0_0_0_0_0_0_1_0_00_00_00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Entered at a falling edge: drive inputs, check combinational outputs,
  // then advance to the next falling edge (one rising edge in between).
  task automatic cyc(input string tag, input logic [14:0] exp, input logic rdy, input logic z);
    mem_ready = rdy;
    zero      = z;
    #1;
    check(tag, 32'(ctrl_obs), 32'(exp));
    @(negedge clk);
  endtask

  task automatic retire_check(input string name);
    exp_ret = exp_ret + 1'b1;
    check({name, "_retired"}, 32'(retired), 32'(exp_ret));
    $display("instr %s: retired=%0d", name, retired);
  endtask

  initial begin
    reset = 1'b1; opcode = 6'b0; zero = 1'b0; mem_ready = 1'b1;
    exp_ret = '0;
    #1;
    check("rst_ctrl", 32'(ctrl_obs), 32'(E_ZERO));
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // R-type
    opcode = 6'b000000;
    cyc("r_fetch", E_FETCH_R, 1'b1, 1'b0);
    cyc("r_decode", E_DECODE, 1'b1, 1'b0);
    cyc("r_exec", E_EXEC, 1'b1, 1'b0);
    check("r_wb_pre_retired", 32'(retired), 32'd0);
    cyc("r_wb", E_R_WB, 1'b1, 1'b0);
    retire_check("R");

    // LW with 3 wait cycles in MEM_RD (8 cycles total)
    opcode = 6'b100011;
    cyc("lw_fetch", E_FETCH_R, 1'b1, 1'b0);
    cyc("lw_decode", E_DECODE, 1'b1, 1'b0);
    cyc("lw_addr", E_MEM_ADDR, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("lw_rd_wait", E_MEM_RD, 1'b0, 1'b0);
    cyc("lw_rd_ready", E_MEM_RD, 1'b1, 1'b0);
    cyc("lw_wb", E_MEM_WB, 1'b1, 1'b0);
    retire_check("LW");

    // BEQ taken / not taken
    opcode = 6'b000100;
    cyc("beq1_fetch", E_FETCH_R, 1'b1, 1'b0);
    cyc("beq1_decode", E_DECODE, 1'b1, 1'b0);
    cyc("beq1_branch", E_BR_Z1, 1'b1, 1'b1);
    retire_check("BEQ_taken");
    cyc("beq0_fetch", E_FETCH_R, 1'b1, 1'b0);
    cyc("beq0_decode", E_DECODE, 1'b1, 1'b0);
    cyc("beq0_branch", E_BR_Z0, 1'b1, 1'b0);
    retire_check("BEQ_not_taken");

    // Fetch stall of 5 cycles, then J
    opcode = 6'b000010;
    for (int i = 0; i < 5; i++) cyc("fetch_stall", E_FETCH_W, 1'b0, 1'b0);
    cyc("j_fetch", E_FETCH_R, 1'b1, 1'b0);
    cyc("j_decode", E_DECODE, 1'b1, 1'b0);
    cyc("j_jump", E_JUMP, 1'b1, 1'b0);
    retire_check("J");

    // SW, memory ready immediately
    opcode = 6'b101011;
    cyc("sw_fetch", E_FETCH_R, 1'b1, 1'b0);
    cyc("sw_decode", E_DECODE, 1'b1, 1'b0);
    cyc("sw_addr", E_MEM_ADDR, 1'b1, 1'b0);
    cyc("sw_wr", E_MEM_WR, 1'b1, 1'b0);
    retire_check("SW");

    // ADDI; mem_ready low in non-memory states must be ignored
    opcode = 6'b001000;
    cyc("addi_fetch", E_FETCH_R, 1'b1, 1'b0);
    cyc("addi_decode", E_DECODE, 1'b0, 1'b0);
    cyc("addi_ex", E_MEM_ADDR, 1'b0, 1'b0);
    cyc("addi_wb", E_ADDI_WB, 1'b0, 1'b0);
    retire_check("ADDI");

    // SW stalled, reset asserted mid MEM_WR
    opcode = 6'b101011;
    cyc("sw2_fetch", E_FETCH_R, 1'b1, 1'b0);
    cyc("sw2_decode", E_DECODE, 1'b1, 1'b0);
    cyc("sw2_addr", E_MEM_ADDR, 1'b1, 1'b0);
    cyc("sw2_wr_wait", E_MEM_WR, 1'b0, 1'b0);
    mem_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_mid_ctrl", 32'(ctrl_obs), 32'(E_ZERO));
    check("rst_mid_retired", 32'(retired), 32'd0);
    $display("instr SW interrupted by reset: retired=%0d", retired);
    @(negedge clk);
    check("rst_hold_ctrl", 32'(ctrl_obs), 32'(E_ZERO));
    reset = 1'b0;
    exp_ret = '0;
    cyc("post_rst_fetch", E_FETCH_W, 1'b0, 1'b0);

    // Counter wrap: 15 jumps reach 15, the 16th wraps to 0
    opcode = 6'b000010;
    for (int k = 0; k < 16; k++) begin
      cyc("wrap_fetch", E_FETCH_R, 1'b1, 1'b0);
      cyc("wrap_decode", E_DECODE, 1'b1, 1'b0);
      cyc("wrap_jump", E_JUMP, 1'b1, 1'b0);
      retire_check("J_wrap");
    end
    check("wrap_zero", 32'(retired), 32'd0);

    // Illegal opcode -> TRAP, absorbing
    opcode = 6'b111111;
    cyc("ill_fetch", E_FETCH_R, 1'b1, 1'b0);
    cyc("ill_decode", E_DECODE, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      opcode = 6'b000010;
      cyc("trap_ctrl", E_ZERO, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("trap_halted", 32'(halted), 32'd1);
      check("trap_retired", 32'(retired), 32'(exp_ret));
    end
    $display("instr ILLEGAL trapped: halted=%0b retired=%0d", halted, retired);
    reset = 1'b1;
    #1;
    check("trap_rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc("trap_rst_fetch", E_FETCH_W, 1'b0, 1'b0);
    check("trap_rst_halted2", 32'(halted), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
